bbpd_sampler: RTL and testbench



---
 rtl/bbpd_sampler_if.sv | 27 ++
 rtl/bbpd_sampler.sv | 168 ++++++++++++++++
 tb/tb_bbpd_sampler.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bbpd_sampler_if.sv
// Port bundle between the NCO/line side (master) and the bang-bang phase detector (slave).
// valid/ready: this link has no back-pressure; edge_tick, sample_tick, data_valid and tick_err are single-cycle strobes acted on in the cycle they are high.
interface bbpd_sampler_if;
    logic              data_in;
    logic              edge_tick;
    logic              sample_tick;
    logic              up_pulse;
    logic              dn_pulse;
    logic              data_out;
    logic              data_valid;
    logic              no_trans;
    logic              tick_err;
    logic signed [7:0] acc_dbg;
    logic        [1:0] pulse_state_dbg;

    modport master (
        output data_in, edge_tick, sample_tick,
        input  up_pulse, dn_pulse, data_out, data_valid, no_trans, tick_err,
        input  acc_dbg, pulse_state_dbg
    );

    modport slave (
        input  data_in, edge_tick, sample_tick,
        output up_pulse, dn_pulse, data_out, data_valid, no_trans, tick_err,
        output acc_dbg, pulse_state_dbg
    );
endinterface

// File: rtl/bbpd_sampler.sv
// Alexander bang-bang phase detector: synchronises the line, samples on edge/centre strobes,
// votes early/late over transitions and emits shaped, mutually exclusive up/dn pulses.
module bbpd_sampler #(
    parameter int SYNC_STAGES  = 2,
    parameter int VOTE_THRESH  = 4,
    parameter int PULSE_CYCLES = 8,
    parameter int RUN_LIMIT    = 64
) (
    input  logic         sys_clk,
    input  logic         rst,
    bbpd_sampler_if.slave pd
);

    localparam logic signed [7:0] THRESH_POS = 8'(VOTE_THRESH);
    localparam logic signed [7:0] THRESH_NEG = -THRESH_POS;
    localparam logic        [7:0] PULSE_LEN  = 8'(PULSE_CYCLES);
    localparam logic       [15:0] RUN_MAX    = 16'(RUN_LIMIT);

    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_UP   = 2'd1,
        PS_DN   = 2'd2
    } pulse_state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   e_reg_q, e_reg_d;
    logic                   e_vld_q, e_vld_d;
    logic                   have_prev_q, have_prev_d;
    logic                   data_out_q, data_out_d;
    logic                   data_valid_q, data_valid_d;
    logic                   tick_err_q, tick_err_d;
    logic                   no_trans_q, no_trans_d;
    logic signed [7:0]      acc_q, acc_d;
    logic [15:0]            run_q, run_d;
    logic [7:0]             pulse_cnt_q, pulse_cnt_d;
    pulse_state_t           state_q, state_d;
    logic                   up_q, up_d;
    logic                   dn_q, dn_d;

    logic                   data_s;
    logic                   edge_only;
    logic                   is_trans;
    logic                   is_same;
    logic                   vote_en;
    logic                   vote_late;
    logic signed [7:0]      acc_next;
    logic                   fire_up;
    logic                   fire_dn;
    logic                   run_enter;

    assign data_s    = sync_q[SYNC_STAGES-1];
    // A simultaneous edge strobe is dropped so the centre sample always wins.
    assign edge_only = pd.edge_tick & ~pd.sample_tick;
    assign is_trans  = have_prev_q & (data_s != data_out_q);
    assign is_same   = have_prev_q & (data_s == data_out_q);
    assign vote_en   = pd.sample_tick & is_trans & e_vld_q;
    assign vote_late = (e_reg_q == data_s);
    assign acc_next  = acc_q + (vote_late ? 8'sd1 : -8'sd1);
    assign fire_up   = vote_en & vote_late & (acc_next == THRESH_POS);
    assign fire_dn   = vote_en & ~vote_late & (acc_next == THRESH_NEG);

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], pd.data_in};
        e_reg_d      = e_reg_q;
        e_vld_d      = e_vld_q;
        have_prev_d  = have_prev_q;
        data_out_d   = data_out_q;
        data_valid_d = pd.sample_tick;
        tick_err_d   = (pd.edge_tick & pd.sample_tick) | (edge_only & e_vld_q);
        acc_d        = acc_q;
        run_d        = run_q;
        run_enter    = 1'b0;

        if (pd.sample_tick) begin
            data_out_d  = data_s;
            have_prev_d = 1'b1;
            e_vld_d     = 1'b0;
            if (is_trans) begin
                run_d = '0;
            end else if (is_same && run_q != RUN_MAX) begin
                run_d     = run_q + 16'd1;
                run_enter = (run_d == RUN_MAX);
            end
        end else if (edge_only) begin
            e_reg_d = data_s;
            e_vld_d = 1'b1;
        end

        if (vote_en) begin
            acc_d = (fire_up || fire_dn) ? 8'sd0 : acc_next;
        end
        // A dead line means stale votes say nothing about the current phase.
        if (run_enter) begin
            acc_d = 8'sd0;
        end

        no_trans_d = (run_d == RUN_MAX);
    end

    // Pulse shaper: a new fire always reloads the counter and takes the output,
    // so an opposite fire hands over on one edge with no overlap or gap.
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        if (fire_up) begin
            state_d     = PS_UP;
            pulse_cnt_d = PULSE_LEN;
        end else if (fire_dn) begin
            state_d     = PS_DN;
            pulse_cnt_d = PULSE_LEN;
        end else if (state_q != PS_IDLE) begin
            if (pulse_cnt_q <= 8'd1) begin
                state_d     = PS_IDLE;
                pulse_cnt_d = '0;
            end else begin
                pulse_cnt_d = pulse_cnt_q - 8'd1;
            end
        end
        up_d = (state_d == PS_UP);
        dn_d = (state_d == PS_DN);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync_q       <= '0;
            e_reg_q      <= 1'b0;
            e_vld_q      <= 1'b0;
            have_prev_q  <= 1'b0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            tick_err_q   <= 1'b0;
            no_trans_q   <= 1'b0;
            acc_q        <= 8'sd0;
            run_q        <= '0;
            pulse_cnt_q  <= '0;
            state_q      <= PS_IDLE;
            up_q         <= 1'b0;
            dn_q         <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            e_reg_q      <= e_reg_d;
            e_vld_q      <= e_vld_d;
            have_prev_q  <= have_prev_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            tick_err_q   <= tick_err_d;
            no_trans_q   <= no_trans_d;
            acc_q        <= acc_d;
            run_q        <= run_d;
            pulse_cnt_q  <= pulse_cnt_d;
            state_q      <= state_d;
            up_q         <= up_d;
            dn_q         <= dn_d;
        end
    end

    assign pd.up_pulse        = up_q;
    assign pd.dn_pulse        = dn_q;
    assign pd.data_out        = data_out_q;
    assign pd.data_valid      = data_valid_q;
    assign pd.no_trans        = no_trans_q;
    assign pd.tick_err        = tick_err_q;
    assign pd.acc_dbg         = acc_q;
    assign pd.pulse_state_dbg = state_q;

    a_pulse_exclusive : assert property (@(posedge sys_clk) disable iff (rst) !(up_q && dn_q));

endmodule

// File: tb/tb_bbpd_sampler.sv
// Bench for bbpd_sampler: directed scenarios plus randomized bit streams, checked every cycle
// against an event-level reference model of the detector.
module tb_bbpd_sampler;

  localparam int SYNC  = 2;
  localparam int THR   = 4;
  localparam int PLEN  = 8;
  localparam int RLIM  = 64;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;

  bbpd_sampler_if pd ();

  bbpd_sampler #(
    .SYNC_STAGES (SYNC),
    .VOTE_THRESH (THR),
    .PULSE_CYCLES(PLEN),
    .RUN_LIMIT   (RLIM)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .pd     (pd)
  );

  // clock / reset
  initial forever #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: event-level description of the detector
  int   m_edge = 0;
  int   m_until = 0;
  int   m_dir = 0;          // 1 = up, 0 = down
  int   m_acc = 0;
  int   m_run = 0;
  bit   m_dout = 0, m_valid = 0, m_err = 0, m_have_prev = 0, m_e_vld = 0, m_e_reg = 0;
  bit   m_hist[$];

  task automatic m_reset();
    m_until = 0; m_acc = 0; m_run = 0;
    m_dout = 0; m_valid = 0; m_err = 0; m_have_prev = 0; m_e_vld = 0; m_e_reg = 0;
    m_hist = {};
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
  endtask

  task automatic m_fire(input int dir);
    m_dir   = dir;
    m_until = m_edge + PLEN;
  endtask

  task automatic m_step();
    bit ds, e, s, din;
    ds  = m_hist[0];
    e   = pd.edge_tick;
    s   = pd.sample_tick;
    din = pd.data_in;
    m_edge++;
    m_valid = s;
    m_err   = (e && s) || (e && !s && m_e_vld);
    if (s) begin
      if (m_have_prev && ds != m_dout) begin
        m_run = 0;
        if (m_e_vld) begin
          m_acc += (m_e_reg == ds) ? 1 : -1;
          if (m_acc == THR) begin m_fire(1); m_acc = 0; end
          else if (m_acc == -THR) begin m_fire(0); m_acc = 0; end
        end
      end else if (m_have_prev && m_run < RLIM) begin
        m_run++;
        if (m_run == RLIM) m_acc = 0;
      end
      m_dout = ds; m_have_prev = 1; m_e_vld = 0;
    end else if (e) begin
      m_e_reg = ds; m_e_vld = 1;
    end
    void'(m_hist.pop_front());
    m_hist.push_back(din);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge sys_clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  // scoreboard compare plus pulse/error cycle counters
  int cnt_up = 0, cnt_dn = 0, cnt_both = 0, cnt_err = 0;

  initial forever begin
    bit exp_up, exp_dn;
    @(negedge sys_clk);
    exp_up = (m_edge < m_until) && (m_dir == 1) && !rst;
    exp_dn = (m_edge < m_until) && (m_dir == 0) && !rst;
    chk("up_pulse",   pd.up_pulse,   exp_up);
    chk("dn_pulse",   pd.dn_pulse,   exp_dn);
    chk("data_out",   pd.data_out,   m_dout);
    chk("data_valid", pd.data_valid, m_valid);
    chk("tick_err",   pd.tick_err,   m_err);
    chk("no_trans",   pd.no_trans,   (m_run == RLIM) ? 1 : 0);
    chk("acc",        int'(pd.acc_dbg), m_acc);
    chk("exclusive",  pd.up_pulse & pd.dn_pulse, 0);
    cnt_up   += pd.up_pulse;
    cnt_dn   += pd.dn_pulse;
    cnt_both += pd.up_pulse & pd.dn_pulse;
    cnt_err  += pd.tick_err;
  end

  // driver tasks: a schedule lists the wanted synchronised line value and strobes per cycle
  bit sq_d[$], sq_e[$], sq_s[$];
  bit tail_v = 0;

  task automatic step(input bit d, input bit e, input bit s);
    @(posedge sys_clk);
    #2;
    pd.data_in     = d;
    pd.edge_tick   = e;
    pd.sample_tick = s;
  endtask

  task automatic idle(input int n);
    repeat (n) step(tail_v, 1'b0, 1'b0);
  endtask

  task automatic push(input bit d, input bit e, input bit s);
    sq_d.push_back(d); sq_e.push_back(e); sq_s.push_back(s);
  endtask

  task automatic add_bit(input bit ee, input bit ev, input bit bv, input int gap);
    for (int i = 0; i < gap; i++) push(tail_v, 1'b0, 1'b0);
    push(ee ? ev : tail_v, ee, 1'b0);
    for (int i = 0; i < gap; i++) push(bv, 1'b0, 1'b0);
    push(bv, 1'b0, 1'b1);
    tail_v = bv;
  endtask

  // line is driven SYNC cycles ahead so data_s matches the schedule on each strobe
  task automatic flush();
    int n, k;
    n = sq_d.size();
    for (int t = -SYNC; t < n; t++) begin
      k = (t + SYNC < n) ? t + SYNC : n - 1;
      step(sq_d[k], (t >= 0) ? sq_e[t] : 1'b0, (t >= 0) ? sq_s[t] : 1'b0);
    end
    sq_d = {}; sq_e = {}; sq_s = {};
  endtask

  task automatic zero_counts();
    cnt_up = 0; cnt_dn = 0; cnt_both = 0; cnt_err = 0;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit nb;
    pd.data_in = 0; pd.edge_tick = 0; pd.sample_tick = 0;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("rst_up", pd.up_pulse, 0);
    chk("rst_dn", pd.dn_pulse, 0);
    chk("rst_data_out", pd.data_out, 0);
    chk("rst_data_valid", pd.data_valid, 0);
    chk("rst_no_trans", pd.no_trans, 0);
    chk("rst_tick_err", pd.tick_err, 0);
    rst = 1'b0;
    idle(2);

    // late clock: four late votes fire one 8-cycle up pulse
    add_bit(1'b0, 1'b0, 1'b0, 2);
    flush(); idle(1);
    zero_counts();
    for (int i = 0; i < 4; i++) begin nb = ~tail_v; add_bit(1'b1, nb, nb, 2); end
    flush(); idle(1);
    chk("t1_up_first", pd.up_pulse, 1);
    chk("t1_dn_first", pd.dn_pulse, 0);
    idle(12);
    chk("t1_up_len", cnt_up, 8);
    chk("t1_dn_len", cnt_dn, 0);
    chk("t1_acc", int'(pd.acc_dbg), 0);

    // early clock, then alternating votes that cancel
    zero_counts();
    for (int i = 0; i < 4; i++) begin nb = ~tail_v; add_bit(1'b1, tail_v, nb, 2); end
    flush(); idle(12);
    chk("t2_dn_len", cnt_dn, 8);
    chk("t2_up_len", cnt_up, 0);
    zero_counts();
    for (int i = 0; i < 8; i++) begin nb = ~tail_v; add_bit(1'b1, (i % 2 == 0) ? nb : tail_v, nb, 1); end
    flush(); idle(12);
    chk("t2_alt_up", cnt_up, 0);
    chk("t2_alt_dn", cnt_dn, 0);
    chk("t2_alt_acc", int'(pd.acc_dbg), 0);

    // run limit: a late transition then 64 identical bits
    add_bit(1'b1, 1'b1, 1'b1, 1);
    for (int i = 0; i < 63; i++) add_bit(1'b1, 1'b1, 1'b1, 1);
    flush(); idle(1);
    chk("t3_no_trans_63", pd.no_trans, 0);
    chk("t3_acc_63", int'(pd.acc_dbg), 1);
    add_bit(1'b1, 1'b1, 1'b1, 1);
    flush(); idle(1);
    chk("t3_no_trans_64", pd.no_trans, 1);
    chk("t3_acc_64", int'(pd.acc_dbg), 0);
    add_bit(1'b0, 1'b0, 1'b0, 1);
    flush(); idle(1);
    chk("t3_no_trans_clr", pd.no_trans, 0);
    chk("t3_acc_clr", int'(pd.acc_dbg), 0);

    // up then down with fastest vote spacing: clean handover, then same-direction extension
    zero_counts();
    for (int i = 0; i < 4; i++) begin nb = ~tail_v; add_bit(1'b1, nb, nb, 0); end
    for (int i = 0; i < 4; i++) begin nb = ~tail_v; add_bit(1'b1, tail_v, nb, 0); end
    flush(); idle(12);
    chk("t4_up_len", cnt_up, 8);
    chk("t4_dn_len", cnt_dn, 8);
    chk("t4_overlap", cnt_both, 0);
    zero_counts();
    for (int i = 0; i < 8; i++) begin nb = ~tail_v; add_bit(1'b1, nb, nb, 0); end
    flush(); idle(20);
    chk("t4_ext_len", cnt_up, 16);

    // simultaneous strobes, then two edges before one sample
    repeat (3) push(1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b1, 1'b1);
    tail_v = 1'b1;
    flush(); idle(1);
    chk("t5_sim_err", pd.tick_err, 1);
    chk("t5_sim_valid", pd.data_valid, 1);
    chk("t5_sim_acc", int'(pd.acc_dbg), 0);
    idle(1);
    chk("t5_sim_err_clr", pd.tick_err, 0);
    zero_counts();
    repeat (2) push(1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b0);
    push(1'b0, 1'b1, 1'b0);
    repeat (2) push(1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b1);
    tail_v = 1'b0;
    flush(); idle(1);
    chk("t5_dbl_err", cnt_err, 1);
    chk("t5_dbl_acc", int'(pd.acc_dbg), 1);

    // reset in the middle of an up pulse
    for (int i = 0; i < 3; i++) begin nb = ~tail_v; add_bit(1'b1, nb, nb, 0); end
    flush(); idle(3);
    chk("t6_up_before", pd.up_pulse, 1);
    @(posedge sys_clk); #2; rst = 1'b1;
    #1;
    chk("t6_up_async", pd.up_pulse, 0);
    idle(2);
    rst = 1'b0;
    add_bit(1'b1, 1'b1, 1'b1, 2);
    flush(); idle(1);
    chk("t6_valid", pd.data_valid, 1);
    chk("t6_data", pd.data_out, 1);
    chk("t6_acc", int'(pd.acc_dbg), 0);

    // randomized streams with strobe errors and occasional resets
    for (int blk = 0; blk < 20; blk++) begin
      for (int i = 0; i < 20; i++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 5) begin
          nb = 1'($urandom_range(0, 1));
          repeat (2) push(nb, 1'b0, 1'b0);
          push(nb, 1'b1, 1'b1);
          tail_v = nb;
        end else if (r < 10) begin
          push(1'($urandom_range(0, 1)), 1'b1, 1'b0);
          push(1'($urandom_range(0, 1)), 1'b1, 1'b0);
          nb = 1'($urandom_range(0, 1));
          push(nb, 1'b0, 1'b0);
          push(nb, 1'b0, 1'b1);
          tail_v = nb;
        end else begin
          nb = ($urandom_range(0, 9) < 7) ? ~tail_v : tail_v;
          add_bit(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), nb, $urandom_range(0, 3));
        end
      end
      flush();
      if ($urandom_range(0, 7) == 0) begin
        @(posedge sys_clk); #2; rst = 1'b1;
        idle(2);
        rst = 1'b0;
      end
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
